count_sequencer: RTL

Command-driven controller that sequences an up/down count register through bounded count passes: single or repeated up-ramps, down-ramps or ping-pong sweeps between 0 and a programmed limit. A requester issues one command over a valid/ready handshake. The block steps the count, flags each pass endpoint and reports completion or abort. It sits between a control/CSR master and any consumer of a bounded sweep, such as an address or timebase.

---
 rtl/count_seq_pkg.sv | 24 ++
 rtl/updown_count_core.sv | 38 +++
 rtl/count_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and default widths for the count_sequencer block.
package count_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LOOPW = 8;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // The reserved encoding runs as an up-ramp.
  function automatic mode_t effective_mode(input logic [1:0] raw);
    return (raw == MODE_RSVD) ? MODE_UP : mode_t'(raw);
  endfunction

endpackage

// File: rtl/updown_count_core.sv
// Loadable up/down count register; exposes the value it will take at the next edge.
module updown_count_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_count_next
);

  logic [WIDTH-1:0] r_count;

  // NOTE: the default assignment first means every path drives o_count_next, so no latch is inferred.
  always_comb begin
    o_count_next = r_count;
    if (i_load) begin
      o_count_next = i_load_val;
    end else if (i_en) begin
      o_count_next = i_up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= o_count_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/count_sequencer.sv
// Command-driven up/down/ping-pong sweep controller between 0 and a programmed limit.
// Defining COUNT_SEQ_PAUSE_EN adds a pause input that freezes a running command.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LOOPW = DEF_LOOPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic [LOOPW-1:0] cmd_loops,
  input  logic             abort,
`ifdef COUNT_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done,
  output logic             aborted
);

  state_t           r_state, w_state_next;
  mode_t            r_mode, w_cmd_mode;
  logic [WIDTH-1:0] r_limit;
  logic [LOOPW-1:0] r_loops_left, w_loops_next;
  logic             r_dir, w_dir_next;
  logic             r_busy, r_tc, r_done, r_aborted;
  logic             w_tc_next, w_done_next, w_aborted_next;
  logic             w_accept, w_step, w_pause, w_pass_end;
  logic             w_load, w_en, w_up;
  logic [WIDTH-1:0] w_load_val, w_count, w_count_next;

`ifdef COUNT_SEQ_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign cmd_ready  = (r_state == S_IDLE);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_step     = (r_state == S_RUN) && !abort && !w_pause;
  assign w_cmd_mode = effective_mode(cmd_mode);

  updown_count_core #(.WIDTH(WIDTH)) u_core (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_load_val   (w_load_val),
    .i_en         (w_en),
    .i_up         (w_up),
    .o_count      (w_count),
    .o_count_next (w_count_next)
  );

  // Step control: pass wraps are loads, everything else is a +/-1 step.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_en       = 1'b0;
    w_up       = 1'b1;
    w_dir_next = r_dir;
    if (w_accept) begin
      w_load = 1'b1;
      if (w_cmd_mode == MODE_DOWN) begin
        w_load_val = cmd_limit;
        w_dir_next = 1'b0;
      end else begin
        w_dir_next = 1'b1;
      end
    end else if (w_step) begin
      case (r_mode)
        MODE_DOWN: begin
          if (w_count == '0) begin
            w_load     = 1'b1;
            w_load_val = r_limit;
          end else begin
            w_en = 1'b1;
            w_up = 1'b0;
          end
        end
        MODE_PINGPONG: begin
          if (r_limit != '0) begin
            w_en = 1'b1;
            if (r_dir) begin
              if (w_count == r_limit) begin
                w_up       = 1'b0;
                w_dir_next = 1'b0;
              end
            end else if (w_count == '0) begin
              w_dir_next = 1'b1;
            end else begin
              w_up = 1'b0;
            end
          end
        end
        default: begin
          if (w_count == r_limit) begin
            w_load = 1'b1;
          end else begin
            w_en = 1'b1;
          end
        end
      endcase
    end
  end

  // Endpoint flags are judged on the value the count takes at this edge.
  always_comb begin
    w_state_next   = r_state;
    w_loops_next   = r_loops_left;
    w_tc_next      = 1'b0;
    w_done_next    = 1'b0;
    w_aborted_next = r_aborted;
    w_pass_end     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next   = S_RUN;
          w_aborted_next = 1'b0;
          w_loops_next   = cmd_loops;
          w_tc_next      = (w_cmd_mode == MODE_PINGPONG) || (cmd_limit == '0);
          w_pass_end     = (cmd_limit == '0);
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_next   = S_IDLE;
          w_done_next    = 1'b1;
          w_aborted_next = 1'b1;
        end else if (!w_pause) begin
          case (r_mode)
            MODE_DOWN: begin
              w_tc_next  = (w_count_next == '0);
              w_pass_end = w_tc_next;
            end
            MODE_PINGPONG: begin
              w_tc_next  = (w_count_next == '0) || (w_count_next == r_limit);
              w_pass_end = (w_count_next == '0);
            end
            default: begin
              w_tc_next  = (w_count_next == r_limit);
              w_pass_end = w_tc_next;
            end
          endcase
        end
      end
    endcase

    // A zero loop count never decrements, so it runs until aborted.
    if (w_pass_end && (w_loops_next != '0)) begin
      if (w_loops_next == LOOPW'(1)) begin
        w_state_next = S_IDLE;
        w_done_next  = 1'b1;
      end else begin
        w_loops_next = w_loops_next - LOOPW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mode       <= MODE_UP;
      r_limit      <= '0;
      r_loops_left <= '0;
      r_dir        <= 1'b1;
      r_busy       <= 1'b0;
      r_tc         <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_loops_left <= w_loops_next;
      r_dir        <= w_dir_next;
      r_busy       <= (w_state_next == S_RUN);
      r_tc         <= w_tc_next;
      r_done       <= w_done_next;
      r_aborted    <= w_aborted_next;
      if (w_accept) begin
        r_mode  <= w_cmd_mode;
        r_limit <= cmd_limit;
      end
    end
  end

  assign count    = w_count;
  assign dir      = r_dir;
  assign busy     = r_busy;
  assign tc_pulse = r_tc;
  assign done     = r_done;
  assign aborted  = r_aborted;

endmodule
